piso_stream: RTL and testbench

- Parametrised parallel-to-serial converter with valid/ready handshakes on both sides.
- Accepts one DATA_W-bit word and emits it as DATA_W/SER_W beats of SER_W bits each, MSB- or LSB-first.
- Marks first/last beat of each word and supports back-to-back words with no bubble.
- Sits between the CDMA spreading/encode stage and the serial link driver of the router channel.

---
 rtl/piso_stream.sv | 176 +++++++++++++++++
 tb/tb_piso_stream.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_stream.sv
// piso_stream: parallel-to-serial converter with valid/ready on both sides.
// One DATA_W-bit word is loaded and sent as DATA_W/SER_W beats of SER_W bits,
// MSB- or LSB-first. First/last beats are flagged. Back-to-back words are
// streamed with no idle cycle between them.
//
// Optional feature (macro PISO_PARITY_EN): one extra beat follows the data
// beats and carries the even parity of the loaded word in bit 0.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a word to load
//   in_ready   block can accept a word this cycle (combinational)
//   in_data    parallel word, sampled only on the load edge
//   out_valid  out_data holds a valid beat
//   out_ready  downstream accepts the beat this cycle
//   out_data   current serial slice
//   out_first  current beat is beat 0 of its word
//   out_last   current beat is the final beat of its word
//   busy       word in flight
module piso_stream #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SER_W     = 1,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SER_W-1:0]  out_data,
  output logic              out_first,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned DBEATS = DATA_W / SER_W;
`ifdef PISO_PARITY_EN
  localparam int unsigned BEATS  = DBEATS + 1;
`else
  localparam int unsigned BEATS  = DBEATS;
`endif
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] shreg_adv;
  logic [SER_W-1:0]  slice_nxt;
  logic [SER_W-1:0]  out_data_nxt;
  logic              out_valid_nxt;
  logic              out_first_nxt;
  logic              out_last_nxt;
`ifdef PISO_PARITY_EN
  logic              par, par_nxt;
`endif

  // Upstream may load when idle, or on the cycle the last beat is taken.
  assign in_ready = (state == IDLE) || ((state == SHIFT) && out_last && out_ready);

  // Shift register advanced by one beat, zero filled.
  always_comb begin
    if (MSB_FIRST != 0) begin
      shreg_adv = shreg << SER_W;
    end else begin
      shreg_adv = shreg >> SER_W;
    end
  end

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
`ifdef PISO_PARITY_EN
    par_nxt   = par;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          shreg_nxt = in_data;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
`ifdef PISO_PARITY_EN
          par_nxt   = ^in_data;
`endif
        end
      end
      SHIFT: begin
        if (out_ready) begin
          if (cnt == LAST_CNT) begin
            if (in_valid) begin
              // Zero-bubble reload on acceptance of the last beat.
              shreg_nxt = in_data;
              cnt_nxt   = '0;
`ifdef PISO_PARITY_EN
              par_nxt   = ^in_data;
`endif
            end else begin
              shreg_nxt = shreg_adv;
              cnt_nxt   = '0;
              state_nxt = IDLE;
`ifdef PISO_PARITY_EN
              par_nxt   = 1'b0;
`endif
            end
          end else begin
            shreg_nxt = shreg_adv;
            cnt_nxt   = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (MSB_FIRST != 0) begin
      slice_nxt = shreg_nxt[DATA_W-1 -: SER_W];
    end else begin
      slice_nxt = shreg_nxt[SER_W-1:0];
    end

    out_valid_nxt = (state_nxt == SHIFT);
    out_first_nxt = (state_nxt == SHIFT) && (cnt_nxt == '0);
    out_last_nxt  = (state_nxt == SHIFT) && (cnt_nxt == LAST_CNT);
    out_data_nxt  = '0;
    if (state_nxt == SHIFT) begin
      out_data_nxt = slice_nxt;
`ifdef PISO_PARITY_EN
      // Trailing beat carries the parity captured at load.
      if (cnt_nxt == CNT_W'(DBEATS)) begin
        out_data_nxt = SER_W'(par_nxt);
      end
`endif
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
`ifdef PISO_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      cnt       <= cnt_nxt;
      out_valid <= out_valid_nxt;
      out_first <= out_first_nxt;
      out_last  <= out_last_nxt;
      busy      <= out_valid_nxt;
      out_data  <= out_data_nxt;
`ifdef PISO_PARITY_EN
      par       <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_piso_stream.sv
// tb_piso_stream: self-checking bench for piso_stream. Three instances
// (8/1/MSB, 8/4/LSB, 8/8/MSB) share the same inputs; each handshakes on its
// own and is tracked by a queue of expected beats built from the word value.
module tb_piso_stream;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       l;
  } beat_t;

  typedef struct packed {
    logic [7:0]  d;
    logic        f;
    logic        l;
    logic [31:0] cyc;
  } log_t;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;

  logic       ovalid [3];
  logic       ofirst [3];
  logic       olast  [3];
  logic       obusy  [3];
  logic       irdy   [3];
  logic [7:0] odat   [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  log_t acc0[$];
  log_t acc1[$];
  log_t acc2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (u%0d) at cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SW   = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
    localparam int MF   = (g == 1) ? 0 : 1;
    localparam int NB   = 8 / SW;
    localparam int MASK = (1 << SW) - 1;

    logic [SW-1:0] od;
    beat_t q[$];

    piso_stream #(.DATA_W(8), .SER_W(SW), .MSB_FIRST(MF)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (irdy[g]),
      .in_data   (in_data),
      .out_valid (ovalid[g]),
      .out_ready (out_ready),
      .out_data  (od),
      .out_first (ofirst[g]),
      .out_last  (olast[g]),
      .busy      (obusy[g])
    );

    assign odat[g] = 8'(od);

    // Cycle-by-cycle comparison against the expected-beat queue.
    always @(negedge clk) begin : cmp
      bit    ev;
      bit    erdy;
      beat_t fr;
      beat_t b;
      log_t  e;
      if (!rst_n) begin
        q.delete();
      end else begin
        ev = (q.size() != 0);
        fr = '0;
        if (ev) fr = q[0];
        erdy = !ev || (fr.l && out_ready);
        chk("out_valid", g, 32'(ovalid[g]), 32'(ev));
        chk("busy", g, 32'(obusy[g]), 32'(ev));
        chk("in_ready", g, 32'(irdy[g]), 32'(erdy));
        if (ev) begin
          chk("out_data", g, 32'(odat[g]), 32'(fr.d));
          chk("out_first", g, 32'(ofirst[g]), 32'(fr.f));
          chk("out_last", g, 32'(olast[g]), 32'(fr.l));
          if (out_ready) begin
            e.d = odat[g];
            e.f = ofirst[g];
            e.l = olast[g];
            e.cyc = 32'(cyc);
            case (g)
              0: acc0.push_back(e);
              1: acc1.push_back(e);
              default: acc2.push_back(e);
            endcase
            void'(q.pop_front());
          end
        end
        if (in_valid && erdy) begin
          for (int i = 0; i < NB; i++) begin
            if (MF != 0) b.d = 8'((int'(in_data) >> (8 - SW * (i + 1))) & MASK);
            else         b.d = 8'((int'(in_data) >> (SW * i)) & MASK);
            b.f = (i == 0);
            b.l = (PAR == 0) && (i == NB - 1);
            q.push_back(b);
          end
          if (PAR != 0) begin
            b.d = 8'(^in_data);
            b.f = 1'b0;
            b.l = 1'b1;
            q.push_back(b);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic load(input logic [7:0] w);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
  endtask

  // Instance 0 (SER_W=1, MSB first) against a literal bit pattern.
  task automatic check_serial(input string name, input logic [7:0] bits, input logic pbit);
    chk({name, " beats"}, 0, 32'(acc0.size()), 32'(8 + PAR));
    if (acc0.size() == 8 + PAR) begin
      for (int i = 0; i < 8; i++) begin
        chk({name, " data"}, 0, 32'(acc0[i].d), 32'(bits[7-i]));
        chk({name, " first"}, 0, 32'(acc0[i].f), 32'(i == 0));
        chk({name, " last"}, 0, 32'(acc0[i].l), 32'((i == 7) && (PAR == 0)));
      end
      if (PAR != 0) begin
        chk({name, " parity"}, 0, 32'(acc0[8].d), 32'(pbit));
        chk({name, " parity last"}, 0, 32'(acc0[8].l), 32'd1);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    for (int g = 0; g < 3; g++) begin
      chk({name, " out_valid"}, g, 32'(ovalid[g]), 32'd0);
      chk({name, " out_first"}, g, 32'(ofirst[g]), 32'd0);
      chk({name, " out_last"}, g, 32'(olast[g]), 32'd0);
      chk({name, " busy"}, g, 32'(obusy[g]), 32'd0);
      chk({name, " out_data"}, g, 32'(odat[g]), 32'd0);
      chk({name, " in_ready"}, g, 32'(irdy[g]), 32'd1);
    end
  endtask

  initial begin : stim
    bit got;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Basic MSB-first word.
    acc0.delete(); acc1.delete(); acc2.delete();
    load(8'hA5);
    idle(12);
    check_serial("basic A5", 8'b10100101, 1'b0);
    chk("idle after word", 0, 32'(ovalid[0]), 32'd0);
    chk("A5 u1 beats", 1, 32'(acc1.size()), 32'(2 + PAR));
    if (acc1.size() >= 2) begin
      chk("A5 u1 beat0", 1, 32'(acc1[0].d), 32'h5);
      chk("A5 u1 beat1", 1, 32'(acc1[1].d), 32'hA);
    end

    // Width/order: 4-bit LSB-first and full-width single beat.
    acc1.delete(); acc2.delete();
    load(8'hB7);
    idle(12);
    chk("B7 u1 beats", 1, 32'(acc1.size()), 32'(2 + PAR));
    if (acc1.size() == 2 + PAR) begin
      chk("B7 u1 beat0", 1, 32'(acc1[0].d), 32'h7);
      chk("B7 u1 beat1", 1, 32'(acc1[1].d), 32'hB);
      chk("B7 u1 first0", 1, 32'(acc1[0].f), 32'd1);
      chk("B7 u1 first1", 1, 32'(acc1[1].f), 32'd0);
      chk("B7 u1 last0", 1, 32'(acc1[0].l), 32'd0);
      chk("B7 u1 last1", 1, 32'(acc1[1].l), 32'(PAR == 0));
    end
    chk("B7 u2 beats", 2, 32'(acc2.size()), 32'(1 + PAR));
    if (acc2.size() == 1 + PAR) begin
      chk("B7 u2 data", 2, 32'(acc2[0].d), 32'hB7);
      chk("B7 u2 first", 2, 32'(acc2[0].f), 32'd1);
      chk("B7 u2 last", 2, 32'(acc2[0].l), 32'(PAR == 0));
    end

    // Back-to-back: F0 then 0F with in_valid held high.
    acc0.delete();
    in_valid = 1'b1;
    in_data  = 8'hF0;
    step();
    in_data = 8'h0F;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (irdy[0]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("b2b in_ready timeout", 0, 32'd0, 32'd1);
    step();
    in_valid = 1'b0;
    idle(25);
    chk("b2b beats", 0, 32'(acc0.size()), 32'(16 + 2 * PAR));
    if (acc0.size() == 16 + 2 * PAR) begin
      for (int i = 0; i < 16 + 2 * PAR; i++) begin
        chk("b2b contiguous", 0, acc0[i].cyc, acc0[0].cyc + 32'(i));
      end
      chk("b2b first beat", 0, 32'(acc0[0].d), 32'd1);
      chk("b2b beat3", 0, 32'(acc0[3].d), 32'd1);
      chk("b2b beat4", 0, 32'(acc0[4].d), 32'd0);
      chk("b2b second first", 0, 32'(acc0[8 + PAR].f), 32'd1);
      chk("b2b second beat0", 0, 32'(acc0[8 + PAR].d), 32'd0);
      chk("b2b second beat7", 0, 32'(acc0[15 + PAR].d), 32'd1);
    end

    // Backpressure at beat 2 for four cycles.
    acc0.delete();
    load(8'hA5);
    step();
    step();
    out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("stall valid", 0, 32'(ovalid[0]), 32'd1);
      chk("stall data", 0, 32'(odat[0]), 32'd1);
      chk("stall first", 0, 32'(ofirst[0]), 32'd0);
      chk("stall last", 0, 32'(olast[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(14);
    check_serial("stall A5", 8'b10100101, 1'b0);
    if (acc0.size() >= 3) chk("stall gap", 0, acc0[2].cyc - acc0[1].cyc, 32'd5);

    // Reset in the middle of a word.
    load(8'hA5);
    idle(3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    acc0.delete();
    load(8'h3C);
    idle(12);
    check_serial("after reset 3C", 8'b00111100, 1'b0);

    // Parity-oriented words.
    acc0.delete();
    load(8'h07);
    idle(12);
    check_serial("word 07", 8'b00000111, 1'b1);
    acc0.delete();
    load(8'h03);
    idle(12);
    check_serial("word 03", 8'b00000011, 1'b0);

    // Randomized traffic, checked by the per-instance models.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(30);
    for (int g = 0; g < 3; g++) chk("drained", g, 32'(ovalid[g]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
